// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed 7-segment driver with a frame-synchronous update buffer:
// CPU writes land in a pending buffer and reach the display only at a frame boundary.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000  // clk cycles per digit slot, minimum 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [7:0]  dp_mask,
  input  logic [7:0]  blank_mask,
  output logic        pending,
  output logic        frame_done,
  output logic [7:0]  AN,
  output logic [6:0]  A2G,
  output logic        DP
);

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  blank;
  } disp_t;

  localparam int               CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic             tick;
  logic             boundary;

  disp_t            pend_buf;
  disp_t            active;

  logic [3:0]       nibble;
  logic [6:0]       seg_next;
  logic [7:0]       an_next;
  logic             dp_next;

  assign tick     = (cnt == CNT_MAX);
  assign boundary = tick && (idx == 3'd7);

  // Digit-slot prescaler and digit index.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
      idx <= 3'd0;
    end else begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      if (tick) begin
        idx <= idx + 3'd1;
      end
    end
  end

  // Pending/active double buffer. A write coinciding with the boundary lands in
  // pending while active takes the value pending held before that edge.
  // NOTE: the buffers are reset explicitly because a reset must discard uncommitted
  // writes and blank the committed image, so they cannot be left as plain storage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_buf   <= '0;
      active     <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (boundary && pending) begin
        active <= pend_buf;
      end
      if (wr_en) begin
        pend_buf <= '{data: wr_data, dp: dp_mask, blank: blank_mask};
        pending  <= 1'b1;
      end else if (boundary) begin
        pending  <= 1'b0;
      end
    end
  end

  // Segment pattern and digit enable for the slot currently indexed.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nibble   = active.data[{idx, 2'b00} +: 4];
    seg_next = 7'b1111111;
    an_next  = 8'hFF;
    dp_next  = ~active.dp[idx];
    if (!active.blank[idx]) begin
      an_next[idx] = 1'b0;
    end
    case (nibble)
      4'h0:    seg_next = 7'b0000001;
      4'h1:    seg_next = 7'b1001111;
      4'h2:    seg_next = 7'b0010010;
      4'h3:    seg_next = 7'b0000110;
      4'h4:    seg_next = 7'b1001100;
      4'h5:    seg_next = 7'b0100100;
      4'h6:    seg_next = 7'b0100000;
      4'h7:    seg_next = 7'b0001111;
      4'h8:    seg_next = 7'b0000000;
      4'h9:    seg_next = 7'b0000100;
      4'hA:    seg_next = 7'b0001000;
      4'hB:    seg_next = 7'b1100000;
      4'hC:    seg_next = 7'b0110001;
      4'hD:    seg_next = 7'b1000010;
      4'hE:    seg_next = 7'b0110000;
      default: seg_next = 7'b0111000;
    endcase
  end

  // Registered pad drivers, one cycle behind idx.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      AN  <= 8'hFF;
      A2G <= 7'h7F;
      DP  <= 1'b1;
    end else begin
      AN  <= an_next;
      A2G <= seg_next;
      DP  <= dp_next;
    end
  end

endmodule
